// File: rtl/irq_priority_ctrl.sv
// irq_priority_ctrl: latches, masks and prioritises NUM_SRC interrupt sources onto one
// registered core interrupt line, with a claim/complete handshake and one source in service.
`default_nettype none

module irq_priority_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic               core_clk,
  input  logic               core_rst,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               cfg_we_i,
  input  logic               cfg_sel_i,
  input  logic [NUM_SRC-1:0] cfg_wdata_i,
  input  logic               claim_req_i,
  output logic               claim_ack_o,
  output logic [ID_W-1:0]    claim_id_o,
  input  logic               complete_i,
  input  logic [ID_W-1:0]    complete_id_i,
  output logic               irq_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] edge_mode;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] src_q;
  logic [ID_W-1:0]    in_service;

  logic [NUM_SRC-1:0] active;
  logic [ID_W-1:0]    winner_id;
  logic               claim_take;
  logic [NUM_SRC-1:0] claim_clr;
  logic [NUM_SRC-1:0] busy_mask;
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] pending_nxt;

  assign active = pending & enable;

  // Scan from the top down so the lowest set index is the last assignment and wins.
  always_comb begin
    winner_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) winner_id = ID_W'(i + 1);
    end
  end

  assign claim_take = (state == IDLE) && claim_req_i && (winner_id != '0);

  always_comb begin
    claim_clr = '0;
    busy_mask = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i] = claim_take && (winner_id == ID_W'(i + 1));
      busy_mask[i] = (state == BUSY) && (in_service == ID_W'(i + 1));
    end
  end

  // A level source being claimed is masked from the claim cycle onward, so a source still
  // high at completion re-pends one cycle after the FSM returns to IDLE.
  assign set_vec = (edge_mode & irq_src_i & ~src_q)
                 | (~edge_mode & irq_src_i & ~busy_mask & ~claim_clr);
  assign clr_vec = claim_clr | (~edge_mode & ~irq_src_i);
  assign pending_nxt = (pending & ~clr_vec) | set_vec;

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state       <= IDLE;
      enable      <= '0;
      edge_mode   <= '0;
      pending     <= '0;
      src_q       <= '0;
      in_service  <= '0;
      irq_o       <= 1'b0;
      claim_ack_o <= 1'b0;
      claim_id_o  <= '0;
    end else begin
      src_q       <= irq_src_i;
      irq_o       <= (state == IDLE) && (|active);
      claim_ack_o <= claim_req_i;
      claim_id_o  <= '0;

      if (cfg_we_i && !cfg_sel_i) enable <= cfg_wdata_i;

      if (cfg_we_i && cfg_sel_i) begin
        edge_mode <= cfg_wdata_i;
        pending   <= '0;
      end else begin
        pending   <= pending_nxt;
      end

      case (state)
        IDLE: begin
          if (claim_req_i) begin
            claim_id_o <= winner_id;
            if (winner_id != '0) begin
              in_service <= winner_id;
              state      <= BUSY;
            end
          end
        end
        BUSY: begin
          // in_service is never zero here, so a zero complete ID cannot match.
          if (complete_i && (complete_id_i == in_service)) begin
            in_service <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_irq_priority_ctrl.sv
// tb_irq_priority_ctrl: directed vectors with hand-computed expectations for irq_priority_ctrl.
`default_nettype none

module tb_irq_priority_ctrl;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 4;

  logic               core_clk = 1'b0;
  logic               core_rst = 1'b1;
  logic [NUM_SRC-1:0] irq_src_i = '0;
  logic               cfg_we_i = 1'b0;
  logic               cfg_sel_i = 1'b0;
  logic [NUM_SRC-1:0] cfg_wdata_i = '0;
  logic               claim_req_i = 1'b0;
  logic               claim_ack_o;
  logic [ID_W-1:0]    claim_id_o;
  logic               complete_i = 1'b0;
  logic [ID_W-1:0]    complete_id_i = '0;
  logic               irq_o;

  int checks = 0;
  int errors = 0;

  irq_priority_ctrl #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
    .core_clk      (core_clk),
    .core_rst      (core_rst),
    .irq_src_i     (irq_src_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_sel_i     (cfg_sel_i),
    .cfg_wdata_i   (cfg_wdata_i),
    .claim_req_i   (claim_req_i),
    .claim_ack_o   (claim_ack_o),
    .claim_id_o    (claim_id_o),
    .complete_i    (complete_i),
    .complete_id_i (complete_id_i),
    .irq_o         (irq_o)
  );

  always #5 core_clk = ~core_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge core_clk);
    #1;
  endtask

  task automatic cfg_write(input logic sel, input logic [NUM_SRC-1:0] data);
    cfg_we_i = 1'b1;
    cfg_sel_i = sel;
    cfg_wdata_i = data;
    step(1);
    cfg_we_i = 1'b0;
  endtask

  task automatic do_claim(input string tag, input logic [ID_W-1:0] exp_id);
    claim_req_i = 1'b1;
    step(1);
    claim_req_i = 1'b0;
    check({tag, "_ack"}, claim_ack_o, 1);
    check({tag, "_id"}, claim_id_o, exp_id);
  endtask

  task automatic do_complete(input logic [ID_W-1:0] id);
    complete_i = 1'b1;
    complete_id_i = id;
    step(1);
    complete_i = 1'b0;
    complete_id_i = '0;
  endtask

  initial begin
    // 1: reset state, level latency, first claim
    step(2);
    check("rst_irq", irq_o, 0);
    check("rst_ack", claim_ack_o, 0);
    check("rst_id", claim_id_o, 0);
    core_rst = 1'b0;
    cfg_write(1'b0, 8'hFF);
    irq_src_i = 8'h08;
    step(1);
    check("t1_irq_lat0", irq_o, 0);
    step(1);
    check("t1_irq_lat1", irq_o, 1);
    do_claim("t1_claim", 4'd4);
    step(1);
    check("t1_ack_drop", claim_ack_o, 0);
    check("t1_id_drop", claim_id_o, 0);
    check("t1_irq_busy", irq_o, 0);
    irq_src_i = 8'h00;
    do_complete(4'd4);
    step(2);
    check("t1_irq_idle", irq_o, 0);

    // 2: simultaneous edges, priority, completion re-raises irq
    cfg_write(1'b1, 8'hFF);
    irq_src_i = 8'h24;
    step(1);
    irq_src_i = 8'h00;
    step(1);
    check("t2_irq", irq_o, 1);
    do_claim("t2_claim_a", 4'd3);
    step(1);
    check("t2_irq_busy", irq_o, 0);
    do_complete(4'd3);
    step(1);
    check("t2_irq_after_cmp", irq_o, 1);
    do_claim("t2_claim_b", 4'd6);
    do_complete(4'd6);
    step(2);
    check("t2_irq_idle", irq_o, 0);

    // 3: spurious claim, claim while busy, bad complete, claim+complete together
    do_claim("t3_spurious", 4'd0);
    irq_src_i = 8'h02;
    step(1);
    irq_src_i = 8'h00;
    step(1);
    check("t3_irq_still_idle", irq_o, 1);
    do_claim("t3_claim", 4'd2);
    do_claim("t3_busy_claim", 4'd0);
    irq_src_i = 8'h10;
    step(1);
    irq_src_i = 8'h00;
    do_complete(4'd7);
    step(2);
    check("t3_bad_cmp_irq", irq_o, 0);
    claim_req_i = 1'b1;
    complete_i = 1'b1;
    complete_id_i = 4'd2;
    step(1);
    claim_req_i = 1'b0;
    complete_i = 1'b0;
    complete_id_i = '0;
    check("t3_both_ack", claim_ack_o, 1);
    check("t3_both_id", claim_id_o, 0);
    step(1);
    check("t3_both_irq", irq_o, 1);
    do_claim("t3_claim_b", 4'd5);
    do_complete(4'd5);

    // 4: edge re-pend during service, level re-pend after completion
    irq_src_i = 8'h01;
    step(1);
    irq_src_i = 8'h00;
    step(1);
    do_claim("t4_claim_a", 4'd1);
    irq_src_i = 8'h01; step(1);
    irq_src_i = 8'h00; step(1);
    irq_src_i = 8'h01; step(1);
    irq_src_i = 8'h00; step(1);
    check("t4_irq_busy", irq_o, 0);
    do_complete(4'd1);
    step(1);
    check("t4_irq_repend", irq_o, 1);
    do_claim("t4_claim_b", 4'd1);
    do_complete(4'd1);
    step(2);
    check("t4_irq_idle", irq_o, 0);
    cfg_write(1'b1, 8'h00);
    irq_src_i = 8'h80;
    step(2);
    check("t4_lvl_irq", irq_o, 1);
    do_claim("t4_lvl_claim_a", 4'd8);
    do_complete(4'd8);
    step(2);
    check("t4_lvl_repend", irq_o, 1);
    do_claim("t4_lvl_claim_b", 4'd8);
    irq_src_i = 8'h00;
    do_complete(4'd8);
    step(2);
    check("t4_lvl_idle", irq_o, 0);

    // 5: enable masking and edge-mode write clearing pending
    cfg_write(1'b0, 8'h00);
    irq_src_i = 8'h02;
    step(3);
    check("t5_masked", irq_o, 0);
    cfg_write(1'b0, 8'h02);
    step(1);
    check("t5_unmasked", irq_o, 1);
    cfg_write(1'b1, 8'h02);
    step(2);
    check("t5_cleared", irq_o, 0);
    do_claim("t5_claim", 4'd0);
    irq_src_i = 8'h00;

    // 6: reset while busy, source held across reset release
    cfg_write(1'b1, 8'h00);
    cfg_write(1'b0, 8'hFF);
    irq_src_i = 8'h81;
    step(2);
    check("t6_irq", irq_o, 1);
    do_claim("t6_claim", 4'd1);
    core_rst = 1'b1;
    claim_req_i = 1'b1;
    step(1);
    claim_req_i = 1'b0;
    check("t6_rst_irq", irq_o, 0);
    check("t6_rst_ack", claim_ack_o, 0);
    check("t6_rst_id", claim_id_o, 0);
    core_rst = 1'b0;
    step(2);
    check("t6_post_rst_irq", irq_o, 0);
    cfg_write(1'b0, 8'hFF);
    step(1);
    check("t6_repend_irq", irq_o, 1);
    do_claim("t6_claim_b", 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
